booth_mac_sequencer: RTL and testbench



---
 rtl/cnn_mac_pkg.sv | 20 ++
 rtl/booth_multiplier.sv | 31 +++
 rtl/booth_mac_sequencer.sv | 113 +++++++++++
 tb/tb_booth_mac_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_mac_pkg.sv
// Shared constants, FSM state type and width helper for the Booth MAC sequencer.
package cnn_mac_pkg;

  localparam int OPER_W = 8;
  localparam int PROD_W = 2 * OPER_W;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Smallest accumulator that holds TAPS full-scale products without wrap.
  function automatic int min_acc_w(input int taps);
    return PROD_W + $clog2(taps);
  endfunction

endpackage

// File: rtl/booth_multiplier.sv
// Combinational radix-2 Booth multiplier: one add/subtract substep per multiplier bit.
module booth_multiplier
  import cnn_mac_pkg::*;
(
  input  logic signed [OPER_W-1:0] i_multiplier,
  input  logic signed [OPER_W-1:0] i_multiplicand,
  output logic signed [PROD_W-1:0] o_product
);

  logic signed [PROD_W-1:0] w_mcand_ext;

  assign w_mcand_ext = {{(PROD_W-OPER_W){i_multiplicand[OPER_W-1]}}, i_multiplicand};

  always_comb begin : booth_steps
    logic signed [PROD_W-1:0] sum;
    logic                     prev;
    // NOTE: combinational logic uses blocking '=' so each substep sees the previous partial sum.
    sum  = '0;
    prev = 1'b0;
    for (int i = 0; i < OPER_W; i++) begin
      case ({i_multiplier[i], prev})
        2'b01:   sum = sum + (w_mcand_ext <<< i);
        2'b10:   sum = sum - (w_mcand_ext <<< i);
        default: ;
      endcase
      prev = i_multiplier[i];
    end
    o_product = sum;
  end

endmodule

// File: rtl/booth_mac_sequencer.sv
// Steps one shared Booth multiplier through a TAPS-long signed dot product and
// returns the wrapped sum over a valid/ready handshake.
module booth_mac_sequencer
  import cnn_mac_pkg::*;
#(
  parameter int TAPS  = 9,
  parameter int ACC_W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic [TAPS*OPER_W-1:0]   i_pixels,
  input  logic [TAPS*OPER_W-1:0]   i_weights,
  output logic                     o_busy,
  output logic                     o_result_valid,
  input  logic                     i_result_ready,
  output logic [ACC_W-1:0]         o_result
);

  if (ACC_W < min_acc_w(TAPS)) begin : g_acc_w_too_narrow
    $error("booth_mac_sequencer: ACC_W too narrow for TAPS");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [IDX_W-1:0]         r_idx;
  logic signed [OPER_W-1:0] r_pix [TAPS];
  logic signed [OPER_W-1:0] r_wgt [TAPS];
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_prod_q;
  logic                     r_prod_v;
  logic [ACC_W-1:0]         r_acc;
  logic [ACC_W-1:0]         r_result;
  logic [ACC_W-1:0]         w_acc_sum;
  logic                     w_accept;

  assign w_accept  = (r_state == ST_IDLE) && i_start;
  assign w_acc_sum = r_acc + {{(ACC_W-PROD_W){r_prod_q[PROD_W-1]}}, r_prod_q};

  booth_multiplier u_booth (
    .i_multiplier   (r_pix[r_idx]),
    .i_multiplicand (r_wgt[r_idx]),
    .o_product      (w_prod)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next_state = ST_MUL;
      ST_MUL:   if (r_idx == LAST_IDX) w_next_state = ST_DRAIN;
      ST_DRAIN: w_next_state = ST_HOLD;
      ST_HOLD:  if (i_result_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: operand storage is a plain memory with no reset; it is always reloaded on acceptance.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < TAPS; k++) begin
        r_pix[k] <= i_pixels[k*OPER_W +: OPER_W];
        r_wgt[k] <= i_weights[k*OPER_W +: OPER_W];
      end
    end
  end

  // The product register lags the index by one cycle, so DRAIN folds in the final tap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= '0;
      r_acc    <= '0;
      r_prod_q <= '0;
      r_prod_v <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_idx    <= '0;
            r_acc    <= '0;
            r_prod_v <= 1'b0;
          end
        end
        ST_MUL: begin
          r_prod_q <= w_prod;
          r_prod_v <= 1'b1;
          if (r_prod_v) r_acc <= w_acc_sum;
          r_idx <= r_idx + IDX_W'(1);
        end
        ST_DRAIN: begin
          r_acc    <= w_acc_sum;
          r_result <= w_acc_sum;
          r_prod_v <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_busy         = (r_state != ST_IDLE);
  assign o_result_valid = (r_state == ST_HOLD);
  assign o_result       = r_result;

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// Scenario bench for booth_mac_sequencer against a plain-arithmetic dot-product model.
module tb_booth_mac_sequencer;

  localparam int TAPS  = 9;
  localparam int ACC_W = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_start;
  logic [TAPS*8-1:0] i_pixels;
  logic [TAPS*8-1:0] i_weights;
  logic              o_busy;
  logic              o_result_valid;
  logic              i_result_ready;
  logic [ACC_W-1:0]  o_result;

  int n_vec = 0;
  int n_err = 0;
  int pix [TAPS];
  int wgt [TAPS];

  always #5 clk = ~clk;

  booth_mac_sequencer #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (i_start),
    .i_pixels       (i_pixels),
    .i_weights      (i_weights),
    .o_busy         (o_busy),
    .o_result_valid (o_result_valid),
    .i_result_ready (i_result_ready),
    .o_result       (o_result)
  );

  function automatic logic [ACC_W-1:0] ref_sum();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(pix[k]) * longint'(wgt[k]);
    return ACC_W'(s);
  endfunction

  task automatic rand_ops();
    for (int k = 0; k < TAPS; k++) begin
      pix[k] = int'($urandom_range(254, 0)) - 127;
      wgt[k] = int'($urandom_range(254, 0)) - 127;
    end
  endtask

  task automatic pack_ops();
    for (int k = 0; k < TAPS; k++) begin
      i_pixels[k*8 +: 8]  = 8'(pix[k]);
      i_weights[k*8 +: 8] = 8'(wgt[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start();
    pack_ops();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Counts edges until result_valid is seen, bounded at 40.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_result_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    i_result_ready = 1'b1;
    tick();
    i_result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 1'b0; i_result_ready = 1'b0;
    i_pixels = '0; i_weights = '0;
    tick(); tick();
    reset = 1'b0;
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_vec++; if (o_result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", o_result_valid); end
    n_vec++; if (o_result !== '0) begin n_err++; $display("FAIL reset_result got %h want 0", o_result); end
  endtask

  task automatic test_ramp();
    int lat;
    for (int k = 0; k < TAPS; k++) begin pix[k] = 1; wgt[k] = k + 1; end
    i_result_ready = 1'b1;
    drive_start();
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL ramp_busy got %b want 1", o_busy); end
    wait_valid(lat);
    n_vec++; if (lat != 10) begin n_err++; $display("FAIL ramp_latency got %0d want 10", lat); end
    n_vec++; if (o_result !== 20'd45) begin n_err++; $display("FAIL ramp_result got %0d want 45", o_result); end
    tick();
    i_result_ready = 1'b0;
    n_vec++; if (o_result_valid !== 1'b0) begin n_err++; $display("FAIL ramp_valid_pulse got %b want 0", o_result_valid); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL ramp_busy_after got %b want 0", o_busy); end
  endtask

  task automatic test_extremes();
    int lat;
    for (int k = 0; k < TAPS; k++) begin pix[k] = 127; wgt[k] = 127; end
    drive_start();
    wait_valid(lat);
    n_vec++; if (o_result !== 20'd145161) begin n_err++; $display("FAIL max_result got %0d want 145161", o_result); end
    n_vec++; if (o_result !== ref_sum()) begin n_err++; $display("FAIL max_model got %h want %h", o_result, ref_sum()); end
    handshake();
    for (int k = 0; k < TAPS; k++) begin pix[k] = -3; wgt[k] = 5; end
    drive_start();
    wait_valid(lat);
    n_vec++; if (o_result !== 20'hFFF79) begin n_err++; $display("FAIL neg_result got %h want fff79", o_result); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [ACC_W-1:0] exp_r;
    rand_ops();
    exp_r = ref_sum();
    drive_start();
    wait_valid(lat);
    n_vec++; if (o_result !== exp_r) begin n_err++; $display("FAIL bp_result got %h want %h", o_result, exp_r); end
    for (int c = 0; c < 5; c++) begin
      rand_ops();
      pack_ops();
      i_start = 1'b1;
      tick();
      n_vec++; if (o_result_valid !== 1'b1 || o_result !== exp_r) begin
        n_err++; $display("FAIL bp_hold_%0d got valid=%b result=%h want valid=1 result=%h", c, o_result_valid, o_result, exp_r);
      end
    end
    i_start = 1'b0;
    handshake();
    n_vec++; if (o_result_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL bp_release got valid=%b busy=%b want 0 0", o_result_valid, o_busy);
    end
    n_vec++; if (o_result !== exp_r) begin n_err++; $display("FAIL bp_result_kept got %h want %h", o_result, exp_r); end
  endtask

  task automatic test_start_while_busy();
    int lat;
    logic [ACC_W-1:0] exp_r;
    rand_ops();
    exp_r = ref_sum();
    i_result_ready = 1'b1;
    drive_start();
    rand_ops();
    pack_ops();
    i_start = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    i_start = 1'b0;
    wait_valid(lat);
    n_vec++; if (lat != 5) begin n_err++; $display("FAIL busy_latency got %0d want 5", lat); end
    n_vec++; if (o_result !== exp_r) begin n_err++; $display("FAIL busy_result got %h want %h", o_result, exp_r); end
    tick();
    i_result_ready = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 15; c++) begin
        if (o_result_valid || o_busy) seen++;
        tick();
      end
      n_vec++; if (seen != 0) begin n_err++; $display("FAIL busy_no_second got %0d active cycles want 0", seen); end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    rand_ops();
    drive_start();
    for (int c = 0; c < 4; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (o_busy !== 1'b0 || o_result_valid !== 1'b0 || o_result !== '0) begin
      n_err++; $display("FAIL midreset got busy=%b valid=%b result=%h want 0 0 0", o_busy, o_result_valid, o_result);
    end
    for (int k = 0; k < TAPS; k++) begin pix[k] = 2; wgt[k] = -1; end
    drive_start();
    wait_valid(lat);
    n_vec++; if (lat != 10) begin n_err++; $display("FAIL midreset_latency got %0d want 10", lat); end
    n_vec++; if (o_result !== 20'hFFFEE) begin n_err++; $display("FAIL midreset_result got %h want fffee", o_result); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [ACC_W-1:0] exp_r;
    rand_ops();
    exp_r = ref_sum();
    i_result_ready = 1'b1;
    drive_start();
    wait_valid(lat);
    n_vec++; if (o_result !== exp_r) begin n_err++; $display("FAIL b2b_first got %h want %h", o_result, exp_r); end
    tick();
    n_vec++; if (o_result_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_handshake got valid=%b busy=%b want 0 0", o_result_valid, o_busy);
    end
    rand_ops();
    exp_r = ref_sum();
    drive_start();
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy=%b want 1", o_busy); end
    wait_valid(lat);
    n_vec++; if (lat != 10 || o_result !== exp_r) begin
      n_err++; $display("FAIL b2b_second got lat=%0d result=%h want lat=10 result=%h", lat, o_result, exp_r);
    end
    tick();
    i_result_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    logic [ACC_W-1:0] exp_r;
    for (int w = 0; w < 20; w++) begin
      rand_ops();
      exp_r = ref_sum();
      drive_start();
      wait_valid(lat);
      n_vec++; if (lat != 10 || o_result !== exp_r) begin
        n_err++; $display("FAIL rand_%0d got lat=%0d result=%h want lat=10 result=%h", w, lat, o_result, exp_r);
      end
      repeat ($urandom_range(3, 0)) tick();
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_extremes();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
